// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid: elastic pipeline register (main + skid slot) with synchronous flush.
// Optional saturating stall counter, built only when PIPE_STALL_CNT_EN is defined.
module pipeline_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Handshake: a transfer happens on a rising clk edge where valid and ready are both 1.
    // valid never depends on ready; in_ready comes straight from a flop (skid occupancy).
    logic              main_valid, main_valid_n;
    logic [DATA_W-1:0] main_data, main_data_n;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_n;
    logic              skid_valid, skid_valid_n;
    logic [DATA_W-1:0] skid_data, skid_data_n;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;
    logic              accept;
    logic              pop;

    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    assign out_valid = main_valid;
    assign pop       = main_valid && out_ready;
    assign out_data  = main_data;
    // Bubbles must never present an asserted control bit to the next stage.
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        main_ctrl_n  = main_ctrl;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_ctrl_n  = skid_ctrl;
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!main_valid) begin
            // Skid is always empty while main is empty.
            if (accept) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
                main_ctrl_n  = in_ctrl;
            end
        end else if (pop) begin
            if (skid_valid) begin
                main_data_n  = skid_data;
                main_ctrl_n  = skid_ctrl;
                skid_valid_n = 1'b0;
            end else if (accept) begin
                main_data_n  = in_data;
                main_ctrl_n  = in_ctrl;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
            skid_ctrl_n  = in_ctrl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else begin
            main_valid <= main_valid_n;
            main_data  <= main_data_n;
            main_ctrl  <= main_ctrl_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            skid_ctrl  <= skid_ctrl_n;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Counts output stalls; flush deliberately leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// tb_pipeline_stage_skid: directed scenarios plus random traffic, checked against a 2-deep FIFO model.
// Build with PIPE_STALL_CNT_EN defined to also check the saturating stall counter (CNT_W=4).
module tb_pipeline_stage_skid;

    localparam int DATA_W    = 32;
    localparam int CTRL_W    = 4;
    localparam int CNT_W     = 4;
    localparam int W         = DATA_W + CTRL_W;
    localparam int STALL_MAX = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    logic [W-1:0] exp_q[$];
    int           exp_stall = 0;
    int           n_checks  = 0;
    int           n_fail    = 0;

    pipeline_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: the stage behaves as a 2-deep FIFO whose ready is (occupancy < 2),
    // evaluated before the edge; flush empties it after any pop of that cycle.
    always @(negedge clk) begin
        int           sz;
        logic [W-1:0] head;
        if (reset) begin
            exp_q.delete();
            exp_stall = 0;
        end else begin
            sz = exp_q.size();
            chk("out_valid", out_valid, sz != 0);
            chk("in_ready", in_ready, sz < 2);
            chk("stall_cnt", stall_cnt, exp_stall);
            if (sz == 0) begin
                chk("out_ctrl_bubble", out_ctrl, 0);
            end else begin
                head = exp_q[0];
                chk("out_data", out_data, head[DATA_W-1:0]);
                chk("out_ctrl", out_ctrl, head[W-1:DATA_W]);
            end
`ifdef PIPE_STALL_CNT_EN
            if (sz != 0 && !out_ready && exp_stall < STALL_MAX) exp_stall++;
`endif
            if (sz != 0 && out_ready) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (in_valid && sz < 2) exp_q.push_back({in_ctrl, in_data});
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        do begin
            @(negedge clk);
            acc = in_ready;
            cyc();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: data %0h not accepted within 50 cycles", d);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        repeat (2) cyc();
        reset = 1'b0;
        cyc();

        // Streaming: 8 back-to-back entries
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            in_ctrl  = 4'b0001;
            chk("stream_in_ready", in_ready, 1);
            cyc();
        end
        in_valid = 1'b0;
        repeat (2) cyc();

        // Backpressure: 0xA in main, 0xB in skid, 0xC held upstream
        out_ready = 1'b0;
        send(32'hA, 4'h2);
        send(32'hB, 4'h3);
        in_valid = 1'b1;
        in_data  = 32'hC;
        in_ctrl  = 4'h4;
        cyc();
        cyc();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_data", out_data, 32'hA);
        out_ready = 1'b1;
        send(32'hC, 4'h4);
        repeat (4) cyc();

        // Flush with both slots full and an offered entry
        out_ready = 1'b0;
        send(32'h1, 4'h1);
        send(32'h2, 4'h2);
        chk("fl_full_in_ready", in_ready, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h3;
        in_ctrl  = 4'hF;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_out_ctrl", out_ctrl, 0);
        chk("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (3) cyc();

        // Flush in the same cycle as a pop
        out_ready = 1'b0;
        send(32'h5, 4'h5);
        out_ready = 1'b1;
        flush     = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flpop_out_valid", out_valid, 0);
        repeat (2) cyc();

        // Long stall: counter saturates at 15 when enabled, stays 0 otherwise
        out_ready = 1'b0;
        send(32'h6, 4'h6);
        repeat (20) cyc();
`ifdef PIPE_STALL_CNT_EN
        chk("stall_saturated", stall_cnt, STALL_MAX);
`else
        chk("stall_disabled", stall_cnt, 0);
`endif
        out_ready = 1'b1;
        repeat (2) cyc();

        // Asynchronous reset mid-stream with both slots full
        out_ready = 1'b0;
        send(32'h7, 4'h1);
        send(32'h8, 4'h2);
        chk("rst_mid_full", in_ready, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_ctrl", out_ctrl, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_stall_cnt", stall_cnt, 0);
        cyc();
        reset     = 1'b0;
        out_ready = 1'b1;
        cyc();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_ctrl   = CTRL_W'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cyc();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();

        // Report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
